// File: rtl/vga_timing_pkg.sv
// Default 640x480 @ 60 Hz timing constants and RRRGGGBB field positions
// shared by the frame scanner and its alignment pipeline.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE_DEF   = 640;
    localparam int unsigned H_FP_DEF        = 16;
    localparam int unsigned H_SYNC_DEF      = 96;
    localparam int unsigned H_BP_DEF        = 48;
    localparam int unsigned V_VISIBLE_DEF   = 480;
    localparam int unsigned V_FP_DEF        = 10;
    localparam int unsigned V_SYNC_DEF      = 2;
    localparam int unsigned V_BP_DEF        = 33;
    localparam int unsigned MAP_LATENCY_DEF = 1;

    localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned HS_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
    localparam int unsigned VS_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_LSB = 5;
    localparam int unsigned G_MSB = 4;
    localparam int unsigned G_LSB = 2;
    localparam int unsigned B_MSB = 1;
    localparam int unsigned B_LSB = 0;

    // Bit order of the {active, hs_n, vs_n} bundle in the alignment pipeline.
    localparam int unsigned CTRL_ACTIVE = 2;
    localparam int unsigned CTRL_HS_N   = 1;
    localparam int unsigned CTRL_VS_N   = 0;
    localparam logic [2:0]  CTRL_RESET  = 3'b011;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register; every stage resets to RESET_VALUE so the
// delayed controls read as idle while the pipeline refills after reset.
module sync_delay_line #(
    parameter int unsigned     DEPTH       = 1,
    parameter int unsigned     WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA pixel-timing master: scan counters, map coordinates, latency-aligned
// sync/blanking and the registered RRRGGGBB pins plus a per-frame tick.
module vga_frame_scanner
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter int unsigned MAP_LATENCY = MAP_LATENCY_DEF
) (
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic [7:0] mapData,
    output logic [9:0] CurrentX,
    output logic [8:0] CurrentY,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [9:0] h_cnt, v_cnt;
    logic       h_last, v_last;
    logic       h_act, v_act;
    logic [2:0] ctrl_raw, ctrl_dly;
    logic [7:0] rgb;

    assign h_last = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 10'd1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end
        end
    end

    assign h_act = (h_cnt < 10'(H_VISIBLE));
    assign v_act = (v_cnt < 10'(V_VISIBLE));

    assign CurrentX = h_act ? h_cnt : '0;
    assign CurrentY = v_act ? v_cnt[8:0] : '0;

    always_comb begin
        ctrl_raw              = CTRL_RESET;
        ctrl_raw[CTRL_ACTIVE] = h_act && v_act;
        ctrl_raw[CTRL_HS_N]   = !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
        ctrl_raw[CTRL_VS_N]   = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));
    end

    sync_delay_line #(
        .DEPTH       (MAP_LATENCY),
        .WIDTH       (3),
        .RESET_VALUE (CTRL_RESET)
    ) u_ctrl_delay (
        .clk   (clk_vga),
        .rst_n (rst_n),
        .d     (ctrl_raw),
        .q     (ctrl_dly)
    );

    // Final register lines the delayed controls up with the map's colour.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= ctrl_dly[CTRL_HS_N];
            vsync       <= ctrl_dly[CTRL_VS_N];
            video_on    <= ctrl_dly[CTRL_ACTIVE];
            rgb         <= ctrl_dly[CTRL_ACTIVE] ? mapData : 8'h00;
            frame_start <= h_last && v_last;
        end
    end

    assign vga_r = rgb[R_MSB:R_LSB];
    assign vga_g = rgb[G_MSB:G_LSB];
    assign vga_b = rgb[B_MSB:B_LSB];

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench: a default-timing scanner fed constant colour and a reduced-timing
// scanner (latency 3) fed a registered copy of its own X coordinate.
module tb_vga_frame_scanner;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    int   hs_low_cnt = 0;
    bit   checking = 1'b0;

    always #5 clk = ~clk;

    // Instance A: 640x480 timing, latency 1, constant map colour.
    logic [7:0] map_a;
    logic [9:0] cx_a;
    logic [8:0] cy_a;
    logic       hs_a, vs_a, von_a, fs_a;
    logic [2:0] r_a, g_a;
    logic [1:0] b_a;

    assign map_a = 8'hB6;

    vga_frame_scanner u_dut_a (
        .clk_vga     (clk),
        .rst_n       (rst_n),
        .mapData     (map_a),
        .CurrentX    (cx_a),
        .CurrentY    (cy_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .video_on    (von_a),
        .vga_r       (r_a),
        .vga_g       (g_a),
        .vga_b       (b_a),
        .frame_start (fs_a)
    );

    // Instance B: 25x15 total timing, latency 3, map returns X[7:0] 3 clocks late.
    logic [7:0] map_b;
    logic [7:0] map_pipe [3];
    logic [9:0] cx_b;
    logic [8:0] cy_b;
    logic       hs_b, vs_b, von_b, fs_b;
    logic [2:0] r_b, g_b;
    logic [1:0] b_b;

    always @(posedge clk) begin
        map_pipe[0] <= cx_b[7:0];
        map_pipe[1] <= map_pipe[0];
        map_pipe[2] <= map_pipe[1];
    end
    assign map_b = map_pipe[2];

    vga_frame_scanner #(
        .H_VISIBLE   (16),
        .H_FP        (2),
        .H_SYNC      (4),
        .H_BP        (3),
        .V_VISIBLE   (8),
        .V_FP        (2),
        .V_SYNC      (2),
        .V_BP        (3),
        .MAP_LATENCY (3)
    ) u_dut_b (
        .clk_vga     (clk),
        .rst_n       (rst_n),
        .mapData     (map_b),
        .CurrentX    (cx_b),
        .CurrentY    (cy_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .video_on    (von_b),
        .vga_r       (r_b),
        .vga_g       (g_b),
        .vga_b       (b_b),
        .frame_start (fs_b)
    );

    // Clocks elapsed since reset release; equals the scan position index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Expected pins from scan arithmetic: pins at clock c show scan index c-lat-1.
    task automatic model_check(
        input string tag, input int c,
        input int hv, input int hfp, input int hsw, input int hbp,
        input int vv, input int vfp, input int vsw, input int vbp,
        input int lat, input bit xmap,
        input int cx, input int cy, input int hsy, input int vsy, input int von,
        input int r, input int g, input int b, input int fs
    );
        int ht, vt, h, v, s, sh, sv;
        int e_hs, e_vs, e_von, col;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        h  = c % ht;
        v  = (c / ht) % vt;
        e_hs  = 1;
        e_vs  = 1;
        e_von = 0;
        col   = 0;
        if (c >= lat + 1) begin
            s  = c - lat - 1;
            sh = s % ht;
            sv = (s / ht) % vt;
            e_hs  = (sh >= hv + hfp && sh < hv + hfp + hsw) ? 0 : 1;
            e_vs  = (sv >= vv + vfp && sv < vv + vfp + vsw) ? 0 : 1;
            e_von = (sh < hv && sv < vv) ? 1 : 0;
            if (e_von == 1) col = xmap ? (sh % 256) : 'hB6;
        end
        chk({tag, ".CurrentX"}, cx, (h < hv) ? h : 0);
        chk({tag, ".CurrentY"}, cy, (v < vv) ? v : 0);
        chk({tag, ".hsync"}, hsy, e_hs);
        chk({tag, ".vsync"}, vsy, e_vs);
        chk({tag, ".video_on"}, von, e_von);
        chk({tag, ".vga_r"}, r, (col >> 5) & 7);
        chk({tag, ".vga_g"}, g, (col >> 2) & 7);
        chk({tag, ".vga_b"}, b, col & 3);
        chk({tag, ".frame_start"}, fs, (c > 0 && h == 0 && v == 0) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            model_check("A", cyc, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0,
                        int'(cx_a), int'(cy_a), int'(hs_a), int'(vs_a), int'(von_a),
                        int'(r_a), int'(g_a), int'(b_a), int'(fs_a));
            model_check("B", cyc, 16, 2, 4, 3, 8, 2, 2, 3, 3, 1'b1,
                        int'(cx_b), int'(cy_b), int'(hs_b), int'(vs_b), int'(von_b),
                        int'(r_b), int'(g_b), int'(b_b), int'(fs_b));
        end
    end

    always @(negedge clk) begin
        if (rst_n && cyc >= 2 && cyc <= 801 && !hs_a) hs_low_cnt <= hs_low_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        int budget = 0;
        while (cyc != n && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: timed out at cyc %0d waiting for %0d", cyc, n);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        checking = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        wait_cyc(1);   chk("A.video_on@1", int'(von_a), 0);
        wait_cyc(2);   chk("A.video_on@2", int'(von_a), 1);
                       chk("A.vga_r@2", int'(r_a), 5);
                       chk("A.vga_g@2", int'(g_a), 5);
                       chk("A.vga_b@2", int'(b_a), 2);
        wait_cyc(21);  chk("B.hsync@21", int'(hs_b), 1);
        wait_cyc(22);  chk("B.hsync@22", int'(hs_b), 0);
        wait_cyc(175); chk("B.CurrentY@175", int'(cy_b), 7);
        wait_cyc(200); chk("B.CurrentY@200", int'(cy_b), 0);
        wait_cyc(253); chk("B.vsync@253", int'(vs_b), 1);
        wait_cyc(254); chk("B.vsync@254", int'(vs_b), 0);
        wait_cyc(374); chk("B.frame_start@374", int'(fs_b), 0);
        wait_cyc(375); chk("B.frame_start@375", int'(fs_b), 1);
        wait_cyc(376); chk("B.frame_start@376", int'(fs_b), 0);
        wait_cyc(639); chk("A.CurrentX@639", int'(cx_a), 639);
        wait_cyc(640); chk("A.CurrentX@640", int'(cx_a), 0);
        wait_cyc(641); chk("A.video_on@641", int'(von_a), 1);
        wait_cyc(642); chk("A.video_on@642", int'(von_a), 0);
                       chk("A.vga_r@642", int'(r_a), 0);
        wait_cyc(657); chk("A.hsync@657", int'(hs_a), 1);
        wait_cyc(658); chk("A.hsync@658", int'(hs_a), 0);
        wait_cyc(753); chk("A.hsync@753", int'(hs_a), 0);
        wait_cyc(754); chk("A.hsync@754", int'(hs_a), 1);
        wait_cyc(800); chk("A.CurrentX@800", int'(cx_a), 0);
                       chk("A.CurrentY@800", int'(cy_a), 1);
        wait_cyc(802); chk("A.hsync_low_clocks", hs_low_cnt, 96);

        // Mid-frame reset while B is inside its visible area (line 5, column 11).
        wait_cyc(2760);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("B.video_on_in_reset", int'(von_b), 0);
        chk("B.CurrentX_in_reset", int'(cx_b), 0);
        chk("B.CurrentY_in_reset", int'(cy_b), 0);
        chk("B.vga_r_in_reset", int'(r_b), 0);
        chk("A.CurrentX_in_reset", int'(cx_a), 0);
        chk("A.vga_g_in_reset", int'(g_a), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        wait_cyc(374); chk("B.frame_start_after_reset@374", int'(fs_b), 0);
        wait_cyc(375); chk("B.frame_start_after_reset@375", int'(fs_b), 1);
        wait_cyc(1200);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
